// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm arm/disarm controller.
//
// Contents:
//   alarm_state_t  controller state encoding (3-bit, fixed values so a
//                  debug probe or checker can decode dbg_state directly)
//   DEFAULT_CODE   factory user code compared against the code switches
//   max_int        elaboration helper used to size the seconds counter
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } alarm_state_t;

    localparam logic [3:0] DEFAULT_CODE = 4'b1010;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/alarm_arm_controller_if.sv
// Panel/sensor signal bundle between the board (buttons, switches, LEDs,
// siren, sensor alarm block) and the arm/disarm controller.
//
// Signals:
//   code_sw    4-bit code switches
//   btn_arm    arm button level (debounced upstream)
//   btn_disarm disarm button level (debounced upstream)
//   a          alarm from the sensor block (already gated by m)
//   m          arm enable to the sensor block
//   siren      siren drive
//   led_armed  armed indicator
//   led_delay  exit/entry delay indicator
//
// Modports:
//   master  board/test side: drives buttons, switches and a
//   slave   controller side: drives m, siren and the LEDs
interface alarm_arm_controller_if;
    import alarm_pkg::*;

    logic [3:0] code_sw;
    logic       btn_arm;
    logic       btn_disarm;
    logic       a;
    logic       m;
    logic       siren;
    logic       led_armed;
    logic       led_delay;

    modport master (
        output code_sw, btn_arm, btn_disarm, a,
        input  m, siren, led_armed, led_delay
    );

    modport slave (
        input  code_sw, btn_arm, btn_disarm, a,
        output m, siren, led_armed, led_delay
    );

endinterface

// File: rtl/alarm_arm_controller_sec_timer.sv
// Seconds timer for the alarm controller.
//
// A prescaler counts 0..CLK_HZ-1; each wrap advances the seconds count.
// Both counters return to 0 on clr (state change) and on reset.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   clr       synchronous clear of prescaler and seconds count
//   sec       seconds elapsed since the last clear
//   last_cyc  high while the prescaler sits at CLK_HZ-1 (last cycle of a second)
module sec_timer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int SEC_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [SEC_W-1:0] sec,
    output logic             last_cyc
);

    localparam int              PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic [SEC_W-1:0] sec_q, sec_d;

    always_comb begin
        ps_d  = ps_q;
        sec_d = sec_q;
        if (clr) begin
            ps_d  = '0;
            sec_d = '0;
        end else if (ps_q == PS_MAX) begin
            ps_d  = '0;
            sec_d = sec_q + SEC_W'(1);
        end else begin
            ps_d  = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q  <= '0;
            sec_q <= '0;
        end else begin
            ps_q  <= ps_d;
            sec_q <= sec_d;
        end
    end

    assign sec      = sec_q;
    assign last_cyc = (ps_q == PS_MAX);

endmodule

// File: rtl/alarm_arm_controller.sv
// Arm/disarm controller for the home alarm system.
//
// Produces the arm enable m for the sensor-OR alarm block and consumes its
// alarm output a. Applies exit and entry delays, checks a 4-bit switch code
// on button presses, counts wrong disarm attempts and drives the siren.
//
// Optional feature, macro ALARM_SIREN_TIMEOUT_EN:
//   defined     ALARM returns to ARMED after SIREN_S seconds (fails cleared)
//   undefined   ALARM holds until a correct disarm or reset; SIREN_S unused
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bus        panel/sensor bundle (slave side): code_sw, btn_arm,
//              btn_disarm, a in; m, siren, led_armed, led_delay out
//   dbg_state  current state register
//   dbg_fails  current wrong-code attempt count
module alarm_arm_controller
    import alarm_pkg::*;
#(
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         EXIT_S    = 10,
    parameter int         ENTRY_S   = 10,
    parameter int         SIREN_S   = 60,
    parameter logic [3:0] CODE      = DEFAULT_CODE,
    parameter int         MAX_TRIES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    alarm_arm_controller_if.slave  bus,
    output alarm_state_t           dbg_state,
    output logic [1:0]             dbg_fails
);

    // Reject parameter sets the counters cannot represent.
    if (EXIT_S < 1 || ENTRY_S < 1 || SIREN_S < 1 || CLK_HZ < 1 ||
        MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_param
        $error("alarm_arm_controller: parameter out of range");
    end

`ifdef ALARM_SIREN_TIMEOUT_EN
    localparam int SEC_MAX = max_int(max_int(EXIT_S, ENTRY_S), SIREN_S);
`else
    localparam int SEC_MAX = max_int(EXIT_S, ENTRY_S);
`endif
    localparam int SEC_W = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;

    // A delay of N seconds ends in the last prescaler cycle of second N-1.
    localparam logic [SEC_W-1:0] EXIT_LAST  = SEC_W'(EXIT_S - 1);
    localparam logic [SEC_W-1:0] ENTRY_LAST = SEC_W'(ENTRY_S - 1);
`ifdef ALARM_SIREN_TIMEOUT_EN
    localparam logic [SEC_W-1:0] SIREN_LAST = SEC_W'(SIREN_S - 1);
`endif
    localparam logic [1:0]       TRIES_LIM  = 2'(MAX_TRIES);

    alarm_state_t     state_q, state_d;
    logic [1:0]       fails_q, fails_d;
    logic             btn_arm_q, btn_arm_d;
    logic             btn_disarm_q, btn_disarm_d;

    logic [SEC_W-1:0] sec;
    logic             last_cyc;
    logic             timer_clr;

    logic             arm_rise;
    logic             disarm_rise;
    logic             code_ok;
    logic             good_disarm;
    logic             wrong_disarm;
    logic [1:0]       fails_inc;
    logic             tries_out;
    logic             exit_done;
    logic             entry_done;
`ifdef ALARM_SIREN_TIMEOUT_EN
    logic             siren_done;
`endif

    sec_timer #(
        .CLK_HZ (CLK_HZ),
        .SEC_W  (SEC_W)
    ) u_sec_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr),
        .sec      (sec),
        .last_cyc (last_cyc)
    );

    // Buttons are plain levels with no handshake: a press acts exactly once,
    // on the cycle its level is first sampled high (rise = level & ~prev),
    // and the code switches are only looked at on that same cycle. Holding
    // a button never produces a second action.
    always_comb begin
        btn_arm_d    = bus.btn_arm;
        btn_disarm_d = bus.btn_disarm;
        arm_rise     = bus.btn_arm & ~btn_arm_q;
        disarm_rise  = bus.btn_disarm & ~btn_disarm_q;
        code_ok      = (bus.code_sw == CODE);
        good_disarm  = disarm_rise & code_ok;
        wrong_disarm = disarm_rise & ~code_ok;
        fails_inc    = (fails_q == 2'd3) ? 2'd3 : fails_q + 2'd1;
        tries_out    = wrong_disarm && (fails_inc >= TRIES_LIM);
        exit_done    = last_cyc && (sec == EXIT_LAST);
        entry_done   = last_cyc && (sec == ENTRY_LAST);
`ifdef ALARM_SIREN_TIMEOUT_EN
        siren_done   = last_cyc && (sec == SIREN_LAST);
`endif
    end

    // Next-state logic. Event priority inside a state:
    // correct disarm > attempt limit reached > delay expiry > sensor alarm.
    always_comb begin
        state_d = state_q;
        fails_d = fails_q;
        case (state_q)
            DISARMED: begin
                // A wrong code on arm is simply ignored.
                if (arm_rise && code_ok) begin
                    state_d = EXIT;
                end
            end
            EXIT: begin
                if (good_disarm) begin
                    state_d = DISARMED;
                end else begin
                    if (wrong_disarm) begin
                        fails_d = fails_inc;
                    end
                    if (tries_out) begin
                        state_d = ALARM;
                    end else if (exit_done) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (good_disarm) begin
                    state_d = DISARMED;
                end else begin
                    if (wrong_disarm) begin
                        fails_d = fails_inc;
                    end
                    if (tries_out) begin
                        state_d = ALARM;
                    end else if (bus.a) begin
                        state_d = ENTRY;
                    end
                end
            end
            ENTRY: begin
                if (good_disarm) begin
                    state_d = DISARMED;
                end else begin
                    if (wrong_disarm) begin
                        fails_d = fails_inc;
                    end
                    if (tries_out || entry_done) begin
                        state_d = ALARM;
                    end
                end
            end
            ALARM: begin
                // Wrong codes are not counted here; the siren is already on.
                if (good_disarm) begin
                    state_d = DISARMED;
                end
`ifdef ALARM_SIREN_TIMEOUT_EN
                else if (siren_done) begin
                    state_d = ARMED;
                    fails_d = '0;
                end
`endif
            end
            default: begin
                state_d = DISARMED;
            end
        endcase

        if (state_d == DISARMED && state_q != DISARMED) begin
            fails_d = '0;
        end
    end

    // Every state change restarts the delay timer from zero.
    assign timer_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DISARMED;
            fails_q      <= '0;
            btn_arm_q    <= 1'b0;
            btn_disarm_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fails_q      <= fails_d;
            btn_arm_q    <= btn_arm_d;
            btn_disarm_q <= btn_disarm_d;
        end
    end

    // Moore output decodes.
    assign bus.m         = (state_q == ARMED) || (state_q == ENTRY) || (state_q == ALARM);
    assign bus.siren     = (state_q == ALARM);
    assign bus.led_armed = (state_q == ARMED) || (state_q == ENTRY) || (state_q == ALARM);
    assign bus.led_delay = (state_q == EXIT) || (state_q == ENTRY);

    assign dbg_state = state_q;
    assign dbg_fails = fails_q;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Bench for alarm_arm_controller: directed scenarios followed by random
// button/code/sensor activity, checked cycle by cycle against a reference
// model that tracks elapsed cycles in each state.
module tb_alarm_arm_controller;
    import alarm_pkg::*;

    localparam int         CLK_HZ    = 10;
    localparam int         EXIT_S    = 2;
    localparam int         ENTRY_S   = 3;
    localparam int         SIREN_S   = 4;
    localparam logic [3:0] CODE      = 4'b1010;
    localparam int         MAX_TRIES = 3;

    localparam int S_DIS   = 0;
    localparam int S_EXIT  = 1;
    localparam int S_ARMED = 2;
    localparam int S_ENTRY = 3;
    localparam int S_ALARM = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alarm_arm_controller_if bus();
    alarm_state_t dbg_state;
    logic [1:0]   dbg_fails;

    alarm_arm_controller #(
        .CLK_HZ    (CLK_HZ),
        .EXIT_S    (EXIT_S),
        .ENTRY_S   (ENTRY_S),
        .SIREN_S   (SIREN_S),
        .CODE      (CODE),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_fails (dbg_fails)
    );

    // ---------------- scoreboard state ----------------
    // {state[2:0], fails[1:0], m, siren, led_armed, led_delay}
    logic [8:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // ---------------- reference model ----------------
    int ms = S_DIS;
    int mfails = 0;
    int mtime = 0;     // edges spent in the current state since entry
    bit pa = 1'b0;
    bit pd = 1'b0;

    function automatic logic [8:0] expect_vec(input int s, input int f);
        logic mm, sr, ld;
        mm = (s == S_ARMED) || (s == S_ENTRY) || (s == S_ALARM);
        sr = (s == S_ALARM);
        ld = (s == S_EXIT) || (s == S_ENTRY);
        return {3'(s), 2'(f), mm, sr, mm, ld};
    endfunction

    task automatic model_step(input logic rst, input logic ba, input logic bd,
                              input logic [3:0] cs, input logic aa);
        int ns, nf;
        bit arise, drise, ok, wrong, trip;
        if (rst) begin
            ms = S_DIS; mfails = 0; mtime = 0; pa = 1'b0; pd = 1'b0;
            return;
        end
        arise = ba && !pa;
        drise = bd && !pd;
        ok    = (cs == CODE);
        ns = ms;
        nf = mfails;
        if (ms == S_DIS) begin
            if (arise && ok) ns = S_EXIT;
        end else if (drise && ok) begin
            ns = S_DIS;
        end else begin
            wrong = drise && !ok && (ms != S_ALARM);
            if (wrong) nf = (mfails < 3) ? mfails + 1 : 3;
            trip = wrong && (nf >= MAX_TRIES);
            if (trip) ns = S_ALARM;
            else if (ms == S_EXIT && mtime + 1 == EXIT_S * CLK_HZ) ns = S_ARMED;
            else if (ms == S_ENTRY && mtime + 1 == ENTRY_S * CLK_HZ) ns = S_ALARM;
`ifdef ALARM_SIREN_TIMEOUT_EN
            else if (ms == S_ALARM && mtime + 1 == SIREN_S * CLK_HZ) begin
                ns = S_ARMED;
                nf = 0;
            end
`endif
            else if (ms == S_ARMED && aa) ns = S_ENTRY;
        end
        if (ns == S_DIS && ms != S_DIS) nf = 0;
        mtime  = (ns != ms) ? 0 : mtime + 1;
        ms     = ns;
        mfails = nf;
        pa     = ba;
        pd     = bd;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst, input logic ba, input logic bd,
                        input logic [3:0] cs, input logic aa);
        @(negedge clk);
        reset          = rst;
        bus.btn_arm    = ba;
        bus.btn_disarm = bd;
        bus.code_sw    = cs;
        bus.a          = aa;
        model_step(rst, ba, bd, cs, aa);
        exp_q.push_back(expect_vec(ms, mfails));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic arm_with_code(input logic [3:0] cs);
        step(1'b0, 1'b1, 1'b0, cs, 1'b0);
        step(1'b0, 1'b0, 1'b0, cs, 1'b0);
    endtask

    task automatic disarm_with_code(input logic [3:0] cs);
        step(1'b0, 1'b0, 1'b1, cs, 1'b0);
        step(1'b0, 1'b0, 1'b0, cs, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [8:0] exp;
        logic [8:0] got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {dbg_state, dbg_fails, bus.m, bus.siren, bus.led_armed, bus.led_delay};
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL outputs cycle %0d: got state=%0d fails=%0d m,siren,led_armed,led_delay=%b, expected state=%0d fails=%0d m,siren,led_armed,led_delay=%b",
                             cyc, got[8:6], got[5:4], got[3:0], exp[8:6], exp[5:4], exp[3:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic ba, bd, aa, rst;
        logic [3:0] cs;
        bus.btn_arm    = 1'b0;
        bus.btn_disarm = 1'b0;
        bus.code_sw    = 4'b0000;
        bus.a          = 1'b0;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        idle(2);

        // Arm with held button, run through exit delay into ARMED
        step(1'b0, 1'b1, 1'b0, CODE, 1'b0);
        step(1'b0, 1'b1, 1'b0, CODE, 1'b0);
        idle(22);

        // Sensor alarm -> ENTRY -> ALARM after entry delay, then linger
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        idle(35);
        idle(200);

        // Reset in the middle of ALARM (or re-armed state with the timeout)
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        idle(3);

        // Three wrong disarms in ENTRY, then correct disarm from ALARM
        arm_with_code(CODE);
        idle(22);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        idle(3);
        repeat (3) disarm_with_code(4'b0000);
        idle(3);
        disarm_with_code(CODE);
        idle(3);

        // Sensor alarm and correct disarm on the same cycle in ARMED
        arm_with_code(CODE);
        idle(22);
        step(1'b0, 1'b0, 1'b1, CODE, 1'b1);
        idle(40);

        // Wrong code arm is ignored; long hold with right code arms once
        arm_with_code(4'b0101);
        idle(3);
        repeat (50) step(1'b0, 1'b1, 1'b0, CODE, 1'b0);
        idle(5);
        disarm_with_code(CODE);
        idle(3);

        // Wrong disarm during EXIT, then correct one
        arm_with_code(CODE);
        disarm_with_code(4'b1111);
        disarm_with_code(CODE);
        idle(3);

        // Random activity: buttons toggle with holds, code mostly correct
        ba = 1'b0;
        bd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ba = ~ba;
            if ($urandom_range(0, 6) == 0) bd = ~bd;
            aa  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 399) == 0);
            cs  = ($urandom_range(0, 2) != 0) ? CODE : 4'($urandom_range(0, 15));
            step(rst, ba, bd, cs, aa);
        end
        idle(5);

        // Drain the scoreboard with a bounded wait
        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
